seq_pattern_tx: RTL and testbench
=================================

SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001: Parameter PATT_W, default 4, SHALL set the pattern width in bits (legal range 2..16).
REQ-002: clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003: rst  input  1  SHALL be the synchronous, active-low reset (0 = reset, sampled on the rising clk edge).
REQ-004: start  input  1  SHALL be the request to transmit, sampled only in IDLE.
REQ-005: patt_in  input  PATT_W  SHALL be the pattern to serialize, sent MSB first.
REQ-006: rep_cnt  input  4  SHALL set the number of extra repetitions; total transmissions = rep_cnt+1.
REQ-007: gap  input  3  SHALL set the idle cycles (valid=0) inserted between consecutive bits.
REQ-008: valid  output  1  SHALL be high only in cycles where d_out carries a pattern bit.
REQ-009: d_out  output  1  SHALL be the serial data bit.
REQ-010: busy  output  1  SHALL be high from the first SEND cycle through the DONE cycle inclusive.
REQ-011: done  output  1  SHALL be a one-cycle pulse marking completion.

Function
REQ-012: The block SHALL be a Moore FSM with states IDLE, SEND, GAP and DONE; all outputs SHALL decode from registered state and datapath only.
REQ-013: In IDLE, start=1 at an edge SHALL capture patt_in, rep_cnt and gap into internal registers and SHALL move the FSM to SEND with bit index PATT_W-1 and rep counter = captured rep_cnt.
REQ-014: Latency: valid SHALL go high with the pattern MSB in the cycle immediately following the capturing edge.
REQ-015: In SEND: valid=1, busy=1, d_out=captured pattern bit at the current index, done=0.
REQ-016: After a SEND cycle that is not the final bit of the final repetition, the FSM SHALL go to GAP if captured gap!=0, else directly to SEND with the next bit.
REQ-017: In GAP: valid=0, d_out=0, busy=1; the FSM SHALL stay exactly captured-gap cycles, then return to SEND.
REQ-018: Bit index SHALL decrement after each SEND; on wrap from 0 it SHALL reload PATT_W-1 and decrement the rep counter.
REQ-019: A gap SHALL be inserted between repetitions (last bit of one, MSB of the next) identically to between bits; no gap SHALL follow the final bit.
REQ-020: After the final bit (index 0, rep counter 0) the FSM SHALL enter DONE for one cycle: done=1, busy=1, valid=0, d_out=0; it then SHALL return to IDLE.
REQ-021: In IDLE: valid=0, d_out=0, busy=0, done=0.
REQ-022: Whenever valid=0, d_out SHALL be 0.
REQ-023: start asserted in SEND, GAP or DONE SHALL be ignored; a new transfer needs start=1 in IDLE.
REQ-024: Changes to patt_in, rep_cnt or gap after capture SHALL NOT affect the transfer in progress.
REQ-025: Busy duration SHALL equal N + gap*(N-1) + 1 cycles, where N = PATT_W*(rep_cnt+1).
REQ-026: Held-high start SHALL re-trigger one cycle after DONE (back-to-back transfers separated by exactly one IDLE cycle).

Reset
REQ-027: With rst=0 at an edge, the FSM SHALL enter IDLE and valid, d_out, busy and done SHALL be 0 from the next cycle.
REQ-028: Reset mid-transfer (SEND, GAP or DONE) SHALL abort immediately with no done pulse; captured registers SHALL clear to 0.
REQ-029: start sampled at the same edge as rst=0 SHALL be ignored.

Verification
REQ-030: patt_in=4'b1011, rep_cnt=0, gap=0, start pulse -> valid high 4 cycles with d_out 1,0,1,1; done=1 in the 5th cycle; busy high 5 cycles.
REQ-031: patt_in=4'b1011, rep_cnt=0, gap=2 -> valid pattern 1,0,0,1,0,0,1,0,0,1 (bits separated by 2 invalid cycles); d_out=0 in gap cycles; busy 11 cycles.
REQ-032: patt_in=4'b1101, rep_cnt=2, gap=1 -> 12 valid bits 1101 1101 1101 each separated by one invalid cycle, including between repetitions; busy 24 cycles; single done pulse.
REQ-033: start re-pulsed and patt_in changed mid-transfer -> transfer continues with the original pattern; no restart; busy stays continuous.
REQ-034: rst=0 asserted during the 3rd valid bit of a gap=0 transfer -> all outputs 0 next cycle, no done pulse; after release, a new start transfers cleanly.
REQ-035: start held high, rep_cnt=0, gap=0 -> transfers repeat with exactly one IDLE cycle (busy=0) between done and the next MSB.

Source files
------------

// File: rtl/seq_pattern_tx.sv
// Serializes a captured PATT_W-bit pattern MSB first, repeated rep_cnt+1 times,
// with a programmable number of idle cycles between consecutive bits.
module seq_pattern_tx #(
  parameter int PATT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PATT_W-1:0] patt_in,
  input  logic [3:0]        rep_cnt,
  input  logic [2:0]        gap,
  output logic              valid,
  output logic              d_out,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = $clog2(PATT_W);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PATT_W - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [PATT_W-1:0]  patt_q, patt_d;
  logic [3:0]         rep_q, rep_d;
  logic [2:0]         gap_q, gap_d;
  logic [2:0]         gcnt_q, gcnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               valid_q, valid_d;
  logic               d_out_q, d_out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Next-state, datapath and output decode; outputs are derived from the
  // next state so that the registered outputs always match the registered state.
  always_comb begin
    state_d = state_q;
    patt_d  = patt_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    idx_d   = idx_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          patt_d  = patt_in;
          rep_d   = rep_cnt;
          gap_d   = gap;
          idx_d   = IDX_MAX;
          gcnt_d  = 3'd0;
          state_d = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if ((idx_q == '0) && (rep_q == 4'd0)) begin
          state_d = ST_DONE;
        end else begin
          if (idx_q == '0) begin
            idx_d = IDX_MAX;
            rep_d = rep_q - 4'd1;
          end else begin
            idx_d = idx_q - IDX_ONE;
          end
          if (gap_q != 3'd0) begin
            gcnt_d  = gap_q - 3'd1;
            state_d = ST_GAP;
          end else begin
            state_d = ST_SEND;
          end
        end
      end
      ST_GAP: begin
        if (gcnt_q == 3'd0) begin
          state_d = ST_SEND;
        end else begin
          gcnt_d  = gcnt_q - 3'd1;
          state_d = ST_GAP;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    valid_d = 1'b0;
    d_out_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_d)
      ST_SEND: begin
        valid_d = 1'b1;
        d_out_d = patt_d[idx_d];
        busy_d  = 1'b1;
      end
      ST_GAP: begin
        busy_d  = 1'b1;
      end
      ST_DONE: begin
        busy_d  = 1'b1;
        done_d  = 1'b1;
      end
      default: begin
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, captured configuration and registered outputs; reset aborts any
  // transfer without a done pulse and clears the captured values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      patt_q  <= '0;
      rep_q   <= 4'd0;
      gap_q   <= 3'd0;
      gcnt_q  <= 3'd0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      d_out_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      patt_q  <= patt_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      d_out_q <= d_out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign valid = valid_q;
  assign d_out = d_out_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed self-checking bench for seq_pattern_tx (PATT_W=4); outputs are
// sampled on the falling clock edge, inputs change on the falling edge.
module tb_seq_pattern_tx;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] patt_in;
  logic [3:0] rep_cnt;
  logic [2:0] gap;
  logic       valid;
  logic       d_out;
  logic       busy;
  logic       done;

  int errors_r;
  int checks_r;

  seq_pattern_tx #(.PATT_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .patt_in (patt_in),
    .rep_cnt (rep_cnt),
    .gap     (gap),
    .valid   (valid),
    .d_out   (d_out),
    .busy    (busy),
    .done    (done)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_r = checks_r + 1;
    if (obs !== exp) begin
      errors_r = errors_r + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Capture edge is the rising edge after this call; start is released after it unless held.
  task automatic kick(input logic [3:0] p, input logic [3:0] r, input logic [2:0] g, input bit hold);
    @(negedge clk);
    patt_in = p;
    rep_cnt = r;
    gap     = g;
    start   = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Samples every cycle after the capture edge until done, recording bits, valid trace and counts.
  task automatic collect(output logic [63:0] bits, output int nbits, output logic [63:0] vtrace,
                         output int busy_cnt, output int done_cnt, output int done_at,
                         output int zero_viol, output logic first_valid, output bit timed_out);
    bits = '0; nbits = 0; vtrace = '0; busy_cnt = 0; done_cnt = 0;
    done_at = 0; zero_viol = 0; first_valid = 1'b0; timed_out = 1'b1;
    for (int cyc = 1; cyc <= 64; cyc++) begin
      @(negedge clk);
      if (cyc == 1) first_valid = valid;
      if (busy) busy_cnt = busy_cnt + 1;
      vtrace = {vtrace[62:0], valid};
      if (valid) begin
        bits  = {bits[62:0], d_out};
        nbits = nbits + 1;
      end else if (d_out !== 1'b0) begin
        zero_viol = zero_viol + 1;
      end
      if (done) begin
        done_cnt = done_cnt + 1;
        done_at  = cyc;
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  logic [63:0] bits_s, vtrace_s;
  int          nbits_s, busy_s, done_cnt_s, done_at_s, zviol_s;
  logic        first_s;
  bit          to_s;

  initial begin
    errors_r = 0;
    checks_r = 0;
    rst = 1'b0; start = 1'b0; patt_in = 4'd0; rep_cnt = 4'd0; gap = 3'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_outs", {60'd0, valid, d_out, busy, done}, 64'd0);
    rst = 1'b1;

    // Basic: 1011, no repeat, no gap
    kick(4'b1011, 4'd0, 3'd0, 1'b0);
    collect(bits_s, nbits_s, vtrace_s, busy_s, done_cnt_s, done_at_s, zviol_s, first_s, to_s);
    check_eq("b_timeout", {63'd0, to_s}, 64'd0);
    check_eq("b_latency", {63'd0, first_s}, 64'd1);
    check_eq("b_bits", bits_s, 64'b1011);
    check_eq("b_nbits", nbits_s, 64'd4);
    check_eq("b_done_at", done_at_s, 64'd5);
    check_eq("b_busy", busy_s, 64'd5);
    @(negedge clk);
    check_eq("b_idle", {60'd0, valid, d_out, busy, done}, 64'd0);

    // Gap of 2 between bits
    kick(4'b1011, 4'd0, 3'd2, 1'b0);
    collect(bits_s, nbits_s, vtrace_s, busy_s, done_cnt_s, done_at_s, zviol_s, first_s, to_s);
    check_eq("g_bits", bits_s, 64'b1011);
    check_eq("g_vtrace", vtrace_s, 64'b10010010010);
    check_eq("g_zero", zviol_s, 64'd0);
    check_eq("g_busy", busy_s, 64'd11);

    // Repeats with gap of 1, including between repetitions
    kick(4'b1101, 4'd2, 3'd1, 1'b0);
    collect(bits_s, nbits_s, vtrace_s, busy_s, done_cnt_s, done_at_s, zviol_s, first_s, to_s);
    check_eq("r_bits", bits_s, 64'b110111011101);
    check_eq("r_nbits", nbits_s, 64'd12);
    check_eq("r_vtrace", vtrace_s, 64'hAAAAAA);
    check_eq("r_busy", busy_s, 64'd24);
    check_eq("r_done_cnt", done_cnt_s, 64'd1);
    @(negedge clk);
    check_eq("r_no_second_done", {63'd0, done}, 64'd0);

    // Mid-transfer start and pattern change are ignored
    kick(4'b1011, 4'd0, 3'd1, 1'b0);
    fork
      collect(bits_s, nbits_s, vtrace_s, busy_s, done_cnt_s, done_at_s, zviol_s, first_s, to_s);
      begin
        repeat (2) @(negedge clk);
        patt_in = 4'b0100; rep_cnt = 4'd3; gap = 3'd0; start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
      end
    join
    check_eq("m_bits", bits_s, 64'b1011);
    check_eq("m_vtrace", vtrace_s, 64'b10101010);
    check_eq("m_busy_cont", busy_s, done_at_s);
    check_eq("m_busy", busy_s, 64'd8);
    @(negedge clk);
    check_eq("m_idle", {63'd0, busy}, 64'd0);

    // Reset during the third valid bit of a gap=0 transfer
    kick(4'b1011, 4'd0, 3'd0, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("x_third_bit", {62'd0, valid, d_out}, 64'b11);
    rst = 1'b0;
    start = 1'b1;
    @(negedge clk);
    check_eq("x_abort", {60'd0, valid, d_out, busy, done}, 64'd0);
    @(negedge clk);
    check_eq("x_start_in_rst", {60'd0, valid, d_out, busy, done}, 64'd0);
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_eq("x_no_done", {62'd0, busy, done}, 64'd0);
    kick(4'b0110, 4'd0, 3'd0, 1'b0);
    collect(bits_s, nbits_s, vtrace_s, busy_s, done_cnt_s, done_at_s, zviol_s, first_s, to_s);
    check_eq("x_bits", bits_s, 64'b0110);
    check_eq("x_busy", busy_s, 64'd5);

    // Held start retriggers after exactly one idle cycle
    kick(4'b1001, 4'd0, 3'd0, 1'b1);
    collect(bits_s, nbits_s, vtrace_s, busy_s, done_cnt_s, done_at_s, zviol_s, first_s, to_s);
    check_eq("h_bits", bits_s, 64'b1001);
    @(negedge clk);
    check_eq("h_idle_gap", {61'd0, valid, busy, done}, 64'd0);
    @(negedge clk);
    check_eq("h_restart", {61'd0, valid, d_out, busy}, 64'b111);
    start = 1'b0;
    collect(bits_s, nbits_s, vtrace_s, busy_s, done_cnt_s, done_at_s, zviol_s, first_s, to_s);
    check_eq("h_second_done", {63'd0, to_s}, 64'd0);
    check_eq("h_second_bits", bits_s, 64'b001);
    @(negedge clk);
    check_eq("h_final_idle", {63'd0, busy}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors_r, checks_r);
    $finish;
  end

endmodule
